// File: rtl/hdc_stream_encoder_if.sv
// hdc_stream_encoder_if: sample-in / frame-HV-out bus of the HDC stream encoder.
//   in_valid/in_ready/input_value : sample handshake (source -> encoder)
//   ch_idx                        : channel index of the next sample the encoder will accept
//   out_valid/out_ready/hv        : bundled frame hypervector handshake (encoder -> sink)
//   hv_pop                        : popcount of hv, present only when ENC_POPCOUNT_EN is defined
// slave = encoder side, master = source/sink side.
interface hdc_stream_encoder_if #(
  parameter int DIM  = 10,
  parameter int IN_W = 32,
  parameter int CH   = 4
);
  localparam int CH_W = (CH > 1) ? $clog2(CH) : 1;
`ifdef ENC_POPCOUNT_EN
  localparam int POP_W = $clog2(DIM + 1);
  logic [POP_W-1:0] hv_pop;
`endif

  logic            in_valid;
  logic            in_ready;
  logic [IN_W-1:0] input_value;
  logic [CH_W-1:0] ch_idx;
  logic            out_valid;
  logic            out_ready;
  logic [DIM-1:0]  hv;

  modport slave (
    input  in_valid, input_value, out_ready,
`ifdef ENC_POPCOUNT_EN
    output hv_pop,
`endif
    output in_ready, ch_idx, out_valid, hv
  );

  modport master (
    output in_valid, input_value, out_ready,
`ifdef ENC_POPCOUNT_EN
    input  hv_pop,
`endif
    input  in_ready, ch_idx, out_valid, hv
  );
endinterface

// File: rtl/hdc_stream_encoder.sv
// hdc_stream_encoder: streams CH samples per frame, quantises each to a level,
// maps it to a level HV (rotated SEED), binds it (XOR) with the rotated channel
// ID HV and bundles the result into per-bit counters. On the last sample of a
// frame a majority threshold produces one DIM-bit HV on a valid/ready output.
// Ports:
//   clk   : clock
//   nrst  : synchronous active-low reset (overrides en)
//   en    : global enable; low freezes all state
//   bus   : hdc_stream_encoder_if.slave (sample handshake, ch_idx, frame HV handshake)
// Optional: define ENC_POPCOUNT_EN to add bus.hv_pop (registered popcount of hv).

// One bit lane: bundling counter plus the registered output bit.
module hdc_stream_encoder_lane #(
  parameter int CNT_W  = 3,
  parameter int THRESH = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic acc,    // sample accepted this cycle
  input  logic last,   // accepted sample closes the frame
  input  logic b,      // bound HV bit for this lane
  output logic hv_d,   // frame result bit if this is the last sample
  output logic hv_q
);
  logic [CNT_W-1:0] cnt;
  logic [CNT_W:0]   sum;

  // The last sample's contribution is folded in combinationally so the result
  // lands on the same edge as the final accept.
  assign sum  = {1'b0, cnt} + (CNT_W+1)'(b);
  assign hv_d = (sum >= (CNT_W+1)'(THRESH));

  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt  <= '0;
      hv_q <= 1'b0;
    end else if (acc) begin
      if (last) begin
        cnt  <= '0;
        hv_q <= hv_d;
      end else begin
        cnt  <= sum[CNT_W-1:0];
      end
    end
  end
endmodule

module hdc_stream_encoder #(
  parameter int             DIM     = 10,
  parameter int             IN_W    = 32,
  parameter int             LVL_W   = 4,
  parameter int             LEVELS  = 16,
  parameter int             CH      = 4,
  parameter logic [DIM-1:0] SEED    = DIM'(10'b0000000111),
  parameter logic [DIM-1:0] ID_SEED = DIM'(10'b0000000001),
  parameter int             THRESH  = 2
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                en,
  hdc_stream_encoder_if.slave bus
);
  localparam int CNT_W = $clog2(CH + 1);
  localparam int CH_W  = (CH > 1) ? $clog2(CH) : 1;

  function automatic logic [DIM-1:0] rotl(input logic [DIM-1:0] x, input int n);
    logic [2*DIM-1:0] t;
    t = {x, x} << n;
    return t[2*DIM-1:DIM];
  endfunction

  logic [CH_W-1:0]  ch_idx;
  logic             out_valid;
  logic             in_ready;
  logic             accept;
  logic             last;
  logic [LVL_W-1:0] lvl_raw;
  logic [LVL_W-1:0] lvl;
  logic [DIM-1:0]   b;
  logic [DIM-1:0]   hv_d;
  logic [DIM-1:0]   hv_q;

  assign in_ready = en & ~out_valid;
  assign accept   = in_ready & bus.in_valid;
  assign last     = (ch_idx == CH_W'(CH - 1));

  // Level = top LVL_W bits of the sample, saturated to the last level.
  assign lvl_raw = bus.input_value[IN_W-1 -: LVL_W];
  assign lvl     = (int'(lvl_raw) > LEVELS - 1) ? LVL_W'(LEVELS - 1) : lvl_raw;
  assign b       = rotl(SEED, int'(lvl) % DIM) ^ rotl(ID_SEED, int'(ch_idx) % DIM);

  for (genvar g = 0; g < DIM; g++) begin : g_lane
    hdc_stream_encoder_lane #(
      .CNT_W (CNT_W),
      .THRESH(THRESH)
    ) u_lane (
      .clk (clk),
      .nrst(nrst),
      .acc (accept),
      .last(last),
      .b   (b[g]),
      .hv_d(hv_d[g]),
      .hv_q(hv_q[g])
    );
  end

  // ACCUM (out_valid=0) accepts samples; HOLD (out_valid=1) waits for the sink.
  // accept already implies en & ~out_valid, so the branches never overlap.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      ch_idx    <= '0;
      out_valid <= 1'b0;
    end else if (en) begin
      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        if (last) begin
          ch_idx    <= '0;
          out_valid <= 1'b1;
        end else begin
          ch_idx    <= ch_idx + CH_W'(1);
        end
      end
    end
  end

`ifdef ENC_POPCOUNT_EN
  localparam int POP_W = $clog2(DIM + 1);
  logic [POP_W-1:0] hv_pop;

  always_ff @(posedge clk) begin
    if (!nrst)               hv_pop <= '0;
    else if (accept && last) hv_pop <= POP_W'($countones(hv_d));
  end

  assign bus.hv_pop = hv_pop;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.ch_idx    = ch_idx;
  assign bus.out_valid = out_valid;
  assign bus.hv        = hv_q;
endmodule
